// File: rtl/mem_cmd_master.sv
// Command-side master for a 1-cycle synchronous memory: one command in, one access, one response out.
// Optional write read-back check enabled by defining MEM_CMD_MASTER_WR_VERIFY_EN.
module mem_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_SIZE   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_read,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_response,
    output logic                  busy
);

`ifdef MEM_CMD_MASTER_WR_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StVrd, StVwait} state_e;
`else
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp} state_e;
`endif

    state_e                state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_is_read_q, rsp_is_read_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  rdata_unknown;

    assign rdata_unknown = $isunknown(mem_rdata);

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mem_wr_d      = 1'b0;
        mem_rd_d      = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (32'(cmd_addr) < MEM_SIZE) begin
                        state_d  = StIssue;
                        mem_wr_d = cmd_wr;
                        mem_rd_d = !cmd_wr;
                    end else begin
                        // Out-of-range: answer immediately without touching memory
                        state_d       = StResp;
                        rsp_valid_d   = 1'b1;
                        rsp_is_read_d = !cmd_wr;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                rsp_valid_d   = 1'b1;
                rsp_is_read_d = !wr_q;
                rsp_rdata_d   = '0;
                state_d       = StResp;
                if (wr_q) begin
                    rsp_err_d = !mem_response;
`ifdef MEM_CMD_MASTER_WR_VERIFY_EN
                    if (mem_response) begin
                        state_d     = StVrd;
                        mem_rd_d    = 1'b1;
                        rsp_valid_d = 1'b0;
                    end
`endif
                end else begin
                    rsp_err_d   = rdata_unknown;
                    rsp_rdata_d = rdata_unknown ? '0 : mem_rdata;
                end
            end
`ifdef MEM_CMD_MASTER_WR_VERIFY_EN
            StVrd: state_d = StVwait;
            StVwait: begin
                state_d       = StResp;
                rsp_valid_d   = 1'b1;
                rsp_is_read_d = 1'b0;
                rsp_rdata_d   = rdata_unknown ? '0 : mem_rdata;
                rsp_err_d     = rdata_unknown || (mem_rdata != wdata_q);
            end
`endif
            StResp: begin
                if (rsp_ready) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b0;
                    rsp_is_read_d = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mem_wr_q      <= mem_wr_d;
            mem_rd_q      <= mem_rd_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_is_read = rsp_is_read_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;

endmodule
